// File: rtl/uart_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO.
// Holds the default bus address of the FIFO data register, the pointer/level
// width helper and the status bundle typedef used inside the top module.
package uart_fifo_pkg;

    // Default bus address that selects the FIFO data register.
    localparam logic [15:0] FIFO_ADDR_DEFAULT = 16'h0000;

    // Pointer and level width: one extra bit beyond the array index so that
    // full (level == DEPTH) and empty (level == 0) can both be represented.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Status flags decoded from the registered occupancy.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
    } fifo_status_t;

endpackage

// File: rtl/uart_fifo_ram_unused_guard.sv
// Minimal companion package for the FIFO storage block.
// Declares a single constant and no logic.
package uart_fifo_ram_guard_pkg;
    localparam int GUARD_UNUSED = 0;
endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x DATA_W storage for the UART transmit FIFO.
// Ports:
//   clk   - system clock, write on rising edge
//   we    - write enable
//   waddr - write index
//   wdata - write data
//   raddr - read index (asynchronous read)
//   rdata - word stored at raddr
// The array is intentionally not reset; the FIFO never exposes unwritten
// entries because the output is gated by the empty flag.
module uart_fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/uart_tx_fifo_sync.sv
// Single-clock transmit FIFO between the bus write port and the UART TX
// serialiser.
// Ports:
//   clk, reset        - clock and asynchronous active-high reset
//   clr               - synchronous clear (empties FIFO, clears overflow)
//   address, fifo_en,
//   data_in           - address-decoded bus write
//   wr_full, rd_empty - occupancy extremes
//   tx_data, tx_valid,
//   tx_ready          - first-word-fall-through stream towards the serialiser
//   level             - current occupancy 0..DEPTH
//   almost_full/empty - threshold flags on level
//   overflow          - sticky: write attempted while full
// All status outputs decode registered state only, so there is no
// combinational path from the bus inputs to any output.
module uart_tx_fifo_sync
    import uart_fifo_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 16,
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] FIFO_ADDR = ADDR_W'(FIFO_ADDR_DEFAULT),
    parameter int                AF_LEVEL  = DEPTH - 2,
    parameter int                AE_LEVEL  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic [ADDR_W-1:0]        address,
    input  logic                     fifo_en,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     wr_full,
    output logic                     rd_empty,
    output logic [DATA_W-1:0]        tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    localparam logic [PW-1:0] DEPTH_LVL = PW'(DEPTH);
    localparam logic [PW-1:0] AF_LVL    = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_LVL    = PW'(AE_LEVEL);
    localparam logic [PW-1:0] ONE_LVL   = PW'(1);

    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [PW-1:0]     level_r;
    logic              overflow_r;

    logic              wr_req_s;
    logic              wr_acc_s;
    logic              pop_s;
    logic              ram_we_s;
    logic [DATA_W-1:0] ram_rdata_s;
    fifo_status_t      status_s;

    // Status bundle decoded from registered occupancy and the sticky flag.
    always_comb begin
        status_s.full         = (level_r == DEPTH_LVL);
        status_s.empty        = (level_r == {PW{1'b0}});
        status_s.almost_full  = (level_r >= AF_LVL);
        status_s.almost_empty = (level_r <= AE_LVL);
        status_s.overflow     = overflow_r;
    end

    // A full FIFO rejects the write even if a pop frees a slot this cycle.
    // A pop needs a valid head, so tx_ready on an empty FIFO is ignored.
    always_comb begin
        wr_req_s = fifo_en && (address == FIFO_ADDR);
        wr_acc_s = wr_req_s && !status_s.full;
        pop_s    = !status_s.empty && tx_ready;
        ram_we_s = wr_acc_s && !clr;
    end

    uart_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (wr_ptr_r[AW-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr_r[AW-1:0]),
        .rdata (ram_rdata_s)
    );

    // Pointer, occupancy and sticky overflow registers; clr outranks traffic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            level_r    <= {PW{1'b0}};
            overflow_r <= 1'b0;
        end else if (clr) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            level_r    <= {PW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_LVL;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_LVL;
            end
            if (wr_req_s && status_s.full) begin
                overflow_r <= 1'b1;
            end
            case ({wr_acc_s, pop_s})
                2'b10:   level_r <= level_r + ONE_LVL;
                2'b01:   level_r <= level_r - ONE_LVL;
                default: level_r <= level_r;
            endcase
        end
    end

    // Output decode; the head word is forced to zero while empty so that
    // never-written storage cannot leak X onto tx_data.
    always_comb begin
        wr_full      = status_s.full;
        rd_empty     = status_s.empty;
        tx_valid     = !status_s.empty;
        almost_full  = status_s.almost_full;
        almost_empty = status_s.almost_empty;
        overflow     = status_s.overflow;
        level        = level_r;
        if (status_s.empty) begin
            tx_data = {DATA_W{1'b0}};
        end else begin
            tx_data = ram_rdata_s;
        end
    end

endmodule
